// File: rtl/kv_pkg.sv
// Shared definitions for the Wishbone key-value store.
// Contents: the command opcode and engine state enums, the register offsets
// (word index, from wbs_adr_i[4:2]) and the STATUS bit positions.
package kv_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_PUT = 2'd1,
      OP_GET = 2'd2,
      OP_DEL = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   localparam logic [2:0] REG_KEY    = 3'd0;
   localparam logic [2:0] REG_VALUE  = 3'd1;
   localparam logic [2:0] REG_CMD    = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;
   localparam logic [2:0] REG_IRQ_EN = 3'd4;

   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_HIT     = 1;
   localparam int unsigned STAT_FULL    = 2;
   localparam int unsigned STAT_DONE    = 3;
   localparam int unsigned STAT_ERR     = 4;
   localparam int unsigned STAT_CNT_LSB = 8;

endpackage

// File: rtl/kv_store_wb_table.sv
// Entry storage for the key-value store: valid/key/value arrays.
// Ports: clk/rst (sync, active-high clear of all entries);
//        rd_idx -> rd_valid/rd_key/rd_val (combinational read);
//        we/wr_idx/wr_key/wr_val/wr_valid (single write port).
module kv_table #(
   parameter int unsigned KEY_W = 16,
   parameter int unsigned VAL_W = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IDX_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [KEY_W-1:0] rd_key,
   output logic [VAL_W-1:0] rd_val,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [KEY_W-1:0] wr_key,
   input  logic [VAL_W-1:0] wr_val,
   input  logic             wr_valid
);

   logic             valid_q [DEPTH];
   logic [KEY_W-1:0] key_q   [DEPTH];
   logic [VAL_W-1:0] val_q   [DEPTH];

   // Entry write / clear; decoded compare keeps the full-width index meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            valid_q[i] <= 1'b0;
            key_q[i]   <= '0;
            val_q[i]   <= '0;
         end else if (we && wr_idx == IDX_W'(i)) begin
            valid_q[i] <= wr_valid;
            key_q[i]   <= wr_key;
            val_q[i]   <= wr_val;
         end
      end
   end

   // Combinational read mux.
   always_comb begin
      rd_valid = 1'b0;
      rd_key   = '0;
      rd_val   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_valid = valid_q[i];
            rd_key   = key_q[i];
            rd_val   = val_q[i];
         end
      end
   end

endmodule

// File: rtl/kv_store_wb.sv
// Wishbone key-value store: register file, Wishbone slave and the scan/commit
// command engine. PUT/GET/DEL scan every entry (fixed latency) then commit.
// Ports: wb_clk_i/wb_rst_i (sync active-high), Wishbone classic slave
//        (wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
//        wbs_ack_o, wbs_dat_o), user_irq = done & IRQ_EN[0].
module kv_store_wb
   import kv_pkg::*;
#(
   parameter int unsigned KEY_W    = 16,
   parameter int unsigned VAL_W    = 32,
   parameter int unsigned DEPTH    = 16,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        user_irq
);

   localparam int unsigned IDX_W = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   // Byte selects and byte-offset bits have no effect: every access is a full word.
   logic unused_ok;
   assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

   // Registers
   logic [KEY_W-1:0] key_q;
   logic [VAL_W-1:0] value_q;
   logic             irq_en_q;
   logic             hit_q, full_q, done_q, err_q;
   logic [IDX_W-1:0] count_q;

   // Latched bus request, executed in the ack cycle
   logic             req_we_q;
   logic [2:0]       req_off_q;
   logic [31:0]      req_dat_q;

   // Engine
   state_e           state, state_n;
   op_e              op_q;
   logic [KEY_W-1:0] op_key_q;
   logic [VAL_W-1:0] op_val_q;
   logic [IDX_W-1:0] scan_idx_q, match_idx_q, free_idx_q;
   logic             match_found_q, free_found_q;

   logic             req_c, wr_c, cmd_wr_c, busy_c;
   logic             start_c, scan_c, commit_c, hit_c;
   logic [31:0]      rd_word_c, status_c;

   logic             tbl_rd_valid;
   logic [KEY_W-1:0] tbl_rd_key;
   logic [VAL_W-1:0] tbl_rd_val;
   logic [IDX_W-1:0] tbl_rd_idx, tbl_wr_idx;
   logic             tbl_we, tbl_wr_valid;

   // Accept a new access only when not acking, so back-to-back strobes get a gap cycle.
   assign req_c    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                     (wbs_adr_i[31:5] == BASE_ADR[31:5]);
   assign wr_c     = wbs_ack_o & req_we_q;
   assign cmd_wr_c = wr_c & (req_off_q == REG_CMD);
   assign busy_c   = (state != ST_IDLE);
   assign user_irq = done_q & irq_en_q;

   // STATUS word assembly.
   always_comb begin
      status_c                          = '0;
      status_c[STAT_BUSY]               = busy_c;
      status_c[STAT_HIT]                = hit_q;
      status_c[STAT_FULL]               = full_q;
      status_c[STAT_DONE]               = done_q;
      status_c[STAT_ERR]                = err_q;
      status_c[STAT_CNT_LSB +: 8]       = 8'(count_q);
   end

   // Read mux; unmapped offsets and CMD read back as zero.
   always_comb begin
      rd_word_c = '0;
      case (wbs_adr_i[4:2])
         REG_KEY:    rd_word_c = 32'(key_q);
         REG_VALUE:  rd_word_c = 32'(value_q);
         REG_STATUS: rd_word_c = status_c;
         REG_IRQ_EN: rd_word_c = 32'(irq_en_q);
         default:    rd_word_c = '0;
      endcase
   end

   // Wishbone slave: one-cycle ack, read data registered alongside it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         req_we_q  <= 1'b0;
         req_off_q <= '0;
         req_dat_q <= '0;
      end else begin
         wbs_ack_o <= req_c;
         wbs_dat_o <= (req_c && !wbs_we_i) ? rd_word_c : '0;
         if (req_c) begin
            req_we_q  <= wbs_we_i;
            req_off_q <= wbs_adr_i[4:2];
            req_dat_q <= wbs_dat_i;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= ST_IDLE;
      else          state <= state_n;
   end

   // FSM next state and engine strobes.
   always_comb begin
      state_n  = state;
      start_c  = 1'b0;
      scan_c   = 1'b0;
      commit_c = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd_wr_c && req_dat_q[1:0] != OP_NOP) begin
               start_c = 1'b1;
               state_n = ST_SCAN;
            end
         end
         ST_SCAN: begin
            scan_c = 1'b1;
            if (scan_idx_q == LAST_IDX) state_n = ST_COMMIT;
         end
         ST_COMMIT: begin
            commit_c = 1'b1;
            state_n  = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign hit_c      = tbl_rd_valid && (tbl_rd_key == op_key_q);
   assign tbl_rd_idx = (state == ST_COMMIT) ? match_idx_q : scan_idx_q;

   // Scan engine: one entry per cycle, keep first match and lowest free slot.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         op_q          <= OP_NOP;
         op_key_q      <= '0;
         op_val_q      <= '0;
         scan_idx_q    <= '0;
         match_idx_q   <= '0;
         free_idx_q    <= '0;
         match_found_q <= 1'b0;
         free_found_q  <= 1'b0;
      end else if (start_c) begin
         op_q          <= op_e'(req_dat_q[1:0]);
         op_key_q      <= key_q;
         op_val_q      <= value_q;
         scan_idx_q    <= '0;
         match_found_q <= 1'b0;
         free_found_q  <= 1'b0;
      end else if (scan_c) begin
         if (hit_c && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= scan_idx_q;
         end
         if (!tbl_rd_valid && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= scan_idx_q;
         end
         if (scan_idx_q != LAST_IDX) scan_idx_q <= scan_idx_q + IDX_W'(1);
      end
   end

   // Table write port driven only in COMMIT.
   always_comb begin
      tbl_we       = 1'b0;
      tbl_wr_idx   = match_idx_q;
      tbl_wr_valid = 1'b1;
      if (commit_c) begin
         case (op_q)
            OP_PUT: begin
               if (match_found_q) begin
                  tbl_we = 1'b1;
               end else if (free_found_q) begin
                  tbl_we     = 1'b1;
                  tbl_wr_idx = free_idx_q;
               end
            end
            OP_DEL: begin
               if (match_found_q) begin
                  tbl_we       = 1'b1;
                  tbl_wr_valid = 1'b0;
               end
            end
            default: tbl_we = 1'b0;
         endcase
      end
   end

   // Register file; commit updates come last so the engine wins any same-cycle write.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         key_q    <= '0;
         value_q  <= '0;
         irq_en_q <= 1'b0;
         hit_q    <= 1'b0;
         full_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         if (wr_c && req_off_q == REG_KEY)    key_q    <= req_dat_q[KEY_W-1:0];
         if (wr_c && req_off_q == REG_VALUE)  value_q  <= req_dat_q[VAL_W-1:0];
         if (wr_c && req_off_q == REG_IRQ_EN) irq_en_q <= req_dat_q[0];
         if (wr_c && req_off_q == REG_STATUS) begin
            if (req_dat_q[STAT_DONE]) done_q <= 1'b0;
            if (req_dat_q[STAT_ERR])  err_q  <= 1'b0;
         end
         if (cmd_wr_c && busy_c) err_q <= 1'b1;
         if (start_c) begin
            hit_q  <= 1'b0;
            full_q <= 1'b0;
         end
         if (commit_c) begin
            done_q <= 1'b1;
            case (op_q)
               OP_PUT: begin
                  if (match_found_q) begin
                     hit_q <= 1'b1;
                  end else if (free_found_q) begin
                     count_q <= count_q + IDX_W'(1);
                  end else begin
                     full_q <= 1'b1;
                     err_q  <= 1'b1;
                  end
               end
               OP_GET: begin
                  if (match_found_q) begin
                     hit_q   <= 1'b1;
                     value_q <= tbl_rd_val;
                  end
               end
               OP_DEL: begin
                  if (match_found_q) begin
                     hit_q   <= 1'b1;
                     count_q <= count_q - IDX_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   kv_table #(
      .KEY_W (KEY_W),
      .VAL_W (VAL_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_table (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .rd_idx   (tbl_rd_idx),
      .rd_valid (tbl_rd_valid),
      .rd_key   (tbl_rd_key),
      .rd_val   (tbl_rd_val),
      .we       (tbl_we),
      .wr_idx   (tbl_wr_idx),
      .wr_key   (op_key_q),
      .wr_val   (op_val_q),
      .wr_valid (tbl_wr_valid)
   );

endmodule

// File: tb/tb_kv_store_wb.sv
// Directed bench for kv_store_wb (DEPTH=8): Wishbone register access,
// PUT/GET/DEL results, full table, busy error, interrupt and mid-scan reset.
module tb_kv_store_wb;

   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam logic [4:0]  A_KEY = 5'h00;
   localparam logic [4:0]  A_VAL = 5'h04;
   localparam logic [4:0]  A_CMD = 5'h08;
   localparam logic [4:0]  A_STA = 5'h0C;
   localparam logic [4:0]  A_IRQ = 5'h10;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_w, dat_r;
   logic        ack, irq;
   logic [31:0] rv;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   kv_store_wb #(
      .KEY_W    (16),
      .VAL_W    (32),
      .DEPTH    (DEPTH),
      .BASE_ADR (BASE)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_w),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_r),
      .user_irq  (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [4:0] off, input logic [31:0] d,
                       output logic [31:0] q);
      bit got;
      got = 1'b0;
      q   = '0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | 32'(off); dat_w = d;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got = 1'b1;
            q   = dat_r;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got) begin
         n_fails++;
         $error("FAIL ack_timeout: observed no ack within 8 cycles expected ack");
      end
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      xfer(1'b1, off, d, dummy);
   endtask

   task automatic rd(input logic [4:0] off, output logic [31:0] q);
      xfer(1'b0, off, 32'h0, q);
   endtask

   task automatic wait_cmd();
      repeat (DEPTH + 3) @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [31:0] key, input logic [31:0] val, input logic [1:0] op);
      wr(A_KEY, key);
      wr(A_VAL, val);
      wr(A_CMD, 32'(op));
      wait_cmd();
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; dat_w = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      // Reset state
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", dat_r, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rd(A_STA, rv); check("rst_status", rv, 32'h0000_0000);
      rd(A_KEY, rv); check("rst_key", rv, 32'h0);
      rd(A_IRQ, rv); check("rst_irq_en", rv, 32'h0);

      // First PUT: ack width and exact done timing through user_irq
      wr(A_KEY, 32'h12);
      wr(A_VAL, 32'hDEAD_BEEF);
      wr(A_IRQ, 32'h1);
      repeat (2) @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE | 32'(A_CMD); dat_w = 32'h1;
      @(posedge clk); #1; check("ack_first", 32'(ack), 32'd1);
      @(posedge clk); #1; check("ack_held_gap", 32'(ack), 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (DEPTH) @(posedge clk);
      #1; check("irq_commit_cycle", 32'(irq), 32'd0);
      @(posedge clk); #1; check("irq_done_cycle", 32'(irq), 32'd1);
      wr(A_STA, 32'h8);
      @(posedge clk); #1; check("irq_after_w1c", 32'(irq), 32'd0);
      rd(A_STA, rv); check("put_new_status", rv, 32'h0000_0100);

      // GET hit
      cmd(32'h12, 32'h0, 2'd2);
      rd(A_VAL, rv); check("get_value", rv, 32'hDEAD_BEEF);
      rd(A_STA, rv); check("get_status", rv, 32'h0000_010A);

      // PUT overwrite, then GET
      wr(A_STA, 32'h18);
      cmd(32'h12, 32'h1, 2'd1);
      rd(A_STA, rv); check("put_ovw_status", rv, 32'h0000_010A);
      cmd(32'h12, 32'h55, 2'd2);
      rd(A_VAL, rv); check("get_ovw_value", rv, 32'h1);

      // DEL, then GET miss leaves VALUE alone
      cmd(32'h12, 32'h0, 2'd3);
      rd(A_STA, rv); check("del_status", rv, 32'h0000_000A);
      cmd(32'h12, 32'h77, 2'd2);
      rd(A_STA, rv); check("get_miss_status", rv, 32'h0000_0008);
      rd(A_VAL, rv); check("get_miss_value", rv, 32'h77);

      // Fill, overflow, free one, retry
      for (int i = 0; i < DEPTH; i++) cmd(32'h100 + 32'(i), 32'(i), 2'd1);
      rd(A_STA, rv); check("fill_status", rv, 32'h0000_0808);
      cmd(32'h200, 32'hAB, 2'd1);
      rd(A_STA, rv); check("full_status", rv, 32'h0000_081C);
      cmd(32'h103, 32'h0, 2'd3);
      rd(A_STA, rv); check("del_full_status", rv, 32'h0000_071A);
      wr(A_STA, 32'h18);
      cmd(32'h200, 32'hAB, 2'd1);
      rd(A_STA, rv); check("retry_status", rv, 32'h0000_0808);
      check("retry_slot3_key", 32'(dut.u_table.key_q[3]), 32'h200);
      cmd(32'h200, 32'h0, 2'd2);
      rd(A_VAL, rv); check("retry_get_value", rv, 32'hAB);

      // CMD while busy sets err; KEY written while busy does not disturb the op
      wr(A_STA, 32'h18);
      wr(A_KEY, 32'h101);
      wr(A_CMD, 32'h2);
      wr(A_CMD, 32'h1);
      wr(A_KEY, 32'h999);
      wait_cmd();
      rd(A_VAL, rv); check("busy_get_value", rv, 32'h1);
      rd(A_STA, rv); check("busy_status", rv, 32'h0000_081A);
      rd(A_KEY, rv); check("busy_key_reg", rv, 32'h999);
      check("irq_on_done", 32'(irq), 32'd1);
      wr(A_STA, 32'h8);
      @(posedge clk); #1; check("irq_cleared", 32'(irq), 32'd0);

      // Unmapped offset reads zero and is acked
      rd(5'h14, rv); check("unmapped_read", rv, 32'h0);

      // Reset mid-scan
      wr(A_KEY, 32'h102);
      wr(A_CMD, 32'h2);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("mid_rst_irq", 32'(irq), 32'd0);
      rd(A_STA, rv); check("mid_rst_status", rv, 32'h0000_0000);
      rd(A_IRQ, rv); check("mid_rst_irq_en", rv, 32'h0);
      cmd(32'h102, 32'h0, 2'd2);
      rd(A_STA, rv); check("post_rst_get_status", rv, 32'h0000_0008);
      rd(A_VAL, rv); check("post_rst_get_value", rv, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
